axis_fifo: RTL and testbench

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_fifo.sv | 242 ++++++++++++++++++++++++
 tb/tb_axis_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo.sv
// AXI-Stream FIFO with optional store-and-forward frame mode.
// Words live in a DEPTH-entry RAM addressed by wrapping pointers one bit wider
// than the address. A single output register sits between the RAM and the
// source port, and it counts toward occupancy so that capacity is exactly DEPTH.
// In frame mode, writes advance a speculative pointer. That pointer is
// published to the read side only when a frame's tlast is accepted; a dropped
// frame rewinds the speculative pointer instead.
module axis_fifo #(
  parameter int DEPTH                = 4096,
  parameter int DATA_WIDTH           = 8,
  parameter int KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH           = (DATA_WIDTH + 7) / 8,
  parameter int LAST_ENABLE          = 1,
  parameter int ID_ENABLE            = 0,
  parameter int ID_WIDTH             = 8,
  parameter int DEST_ENABLE          = 0,
  parameter int DEST_WIDTH           = 8,
  parameter int USER_ENABLE          = 0,
  parameter int USER_WIDTH           = 1,
  parameter int FRAME_FIFO           = 0,
  parameter int USER_BAD_FRAME_VALUE = 1,
  parameter int USER_BAD_FRAME_MASK  = 1,
  parameter int DROP_OVERSIZE_FRAME  = FRAME_FIFO,
  parameter int DROP_BAD_FRAME       = 0,
  parameter int DROP_WHEN_FULL       = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [ID_WIDTH-1:0]      s_axis_tid,
  input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser,

  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [ID_WIDTH-1:0]      m_axis_tid,
  output logic [DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [USER_WIDTH-1:0]    m_axis_tuser,

  output logic [$clog2(DEPTH):0]   status_depth,
  output logic [$clog2(DEPTH):0]   status_depth_commit,
  output logic                     status_overflow,
  output logic                     status_bad_frame,
  output logic                     status_good_frame
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  // Packed RAM word layout: only enabled fields take RAM bits.
  localparam int KEEP_OFF = DATA_WIDTH;
  localparam int LAST_OFF = KEEP_OFF + ((KEEP_ENABLE != 0) ? KEEP_WIDTH : 0);
  localparam int ID_OFF   = LAST_OFF + ((LAST_ENABLE != 0) ? 1 : 0);
  localparam int DEST_OFF = ID_OFF   + ((ID_ENABLE   != 0) ? ID_WIDTH   : 0);
  localparam int USER_OFF = DEST_OFF + ((DEST_ENABLE != 0) ? DEST_WIDTH : 0);
  localparam int WIDTH    = USER_OFF + ((USER_ENABLE != 0) ? USER_WIDTH : 0);
  // Scratch width that can hold every field, so field slices never run off the end.
  localparam int EXT_W    = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  // The drop options only make sense for store-and-forward operation.
  localparam bit FRAME_MODE  = (FRAME_FIFO != 0);
  localparam bit DO_OVERSIZE = FRAME_MODE && (DROP_OVERSIZE_FRAME != 0);
  localparam bit DO_BAD      = FRAME_MODE && (DROP_BAD_FRAME != 0);
  localparam bit DO_FULL     = FRAME_MODE && (DROP_WHEN_FULL != 0);

  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [USER_WIDTH-1:0] BAD_MASK = USER_WIDTH'(USER_BAD_FRAME_MASK);
  localparam logic [USER_WIDTH-1:0] BAD_VAL  = USER_WIDTH'(USER_BAD_FRAME_VALUE);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [EXT_W-1:0] s_ext;
  logic [EXT_W-1:0] out_ext;
  logic [WIDTH-1:0] s_word;
  logic [WIDTH-1:0] out_word_p1;
  logic             vld_p1;

  logic [PTR_W-1:0] wr_ptr_commit;
  logic [PTR_W-1:0] wr_ptr_cur;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fetch_ptr;

  logic ready_en;
  logic drop_frame;
  logic full_cur;
  logic full_wr;
  logic fetch_empty;
  logic s_hs;
  logic m_hs;
  logic fetch;
  logic s_last;
  logic s_bad;
  logic drop_word;
  logic mem_we;

  // Occupancy is measured against rd_ptr, which retires a word only when the
  // source accepts it. The word held in the output register still counts.
  assign full_cur    = (wr_ptr_cur == {~rd_ptr[PTR_W-1], rd_ptr[ADDR_W-1:0]});
  assign full_wr     = (wr_ptr_cur == {~wr_ptr_commit[PTR_W-1], wr_ptr_commit[ADDR_W-1:0]});
  assign fetch_empty = (wr_ptr_commit == fetch_ptr);

  assign s_last    = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
  assign s_bad     = ((s_axis_tuser & BAD_MASK) == BAD_VAL);
  assign drop_word = (DO_FULL && full_cur) || (DO_OVERSIZE && full_wr);
  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign mem_we    = s_hs && (!FRAME_MODE || !(drop_frame || drop_word));

  assign m_axis_tvalid = vld_p1;
  assign m_hs          = vld_p1 && m_axis_tready;
  assign fetch         = !fetch_empty && (!vld_p1 || m_axis_tready);

  assign status_depth        = wr_ptr_cur - rd_ptr;
  assign status_depth_commit = wr_ptr_commit - rd_ptr;

  // Sink ready: held low until the first edge out of reset. In drop modes,
  // ready stays high so that a frame being discarded can always drain through
  // to its tlast.
  always_comb begin
    s_axis_tready = 1'b0;
    if (ready_en) begin
      if (FRAME_MODE) begin
        s_axis_tready = !full_cur || drop_frame || DO_FULL || (DO_OVERSIZE && full_wr);
      end else begin
        s_axis_tready = !full_cur;
      end
    end
  end

  // Pack the enabled sink fields into one RAM word.
  always_comb begin
    s_ext = '0;
    s_ext[DATA_WIDTH-1:0] = s_axis_tdata;
    if (KEEP_ENABLE != 0) s_ext[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
    if (LAST_ENABLE != 0) s_ext[LAST_OFF] = s_axis_tlast;
    if (ID_ENABLE   != 0) s_ext[ID_OFF   +: ID_WIDTH]   = s_axis_tid;
    if (DEST_ENABLE != 0) s_ext[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
    if (USER_ENABLE != 0) s_ext[USER_OFF +: USER_WIDTH] = s_axis_tuser;
    s_word = s_ext[WIDTH-1:0];
  end

  // Write side: speculative and committed pointers, frame drop state, status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_commit     <= '0;
      wr_ptr_cur        <= '0;
      drop_frame        <= 1'b0;
      ready_en          <= 1'b0;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      ready_en          <= 1'b1;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
      if (s_hs) begin
        if (!FRAME_MODE) begin
          wr_ptr_cur    <= wr_ptr_cur + PTR_ONE;
          wr_ptr_commit <= wr_ptr_cur + PTR_ONE;
        end else if (drop_frame || drop_word) begin
          wr_ptr_cur <= wr_ptr_commit;
          if (s_last) begin
            drop_frame      <= 1'b0;
            status_overflow <= 1'b1;
          end else begin
            drop_frame <= 1'b1;
          end
        end else begin
          wr_ptr_cur <= wr_ptr_cur + PTR_ONE;
          if (s_last) begin
            if (s_bad) begin
              status_bad_frame <= 1'b1;
              if (DO_BAD) begin
                wr_ptr_cur <= wr_ptr_commit;
              end else begin
                wr_ptr_commit <= wr_ptr_cur + PTR_ONE;
              end
            end else begin
              status_good_frame <= 1'b1;
              wr_ptr_commit     <= wr_ptr_cur + PTR_ONE;
            end
          end
        end
      end
    end
  end

  // RAM write port and output-register load (payload only, no reset).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_cur[ADDR_W-1:0]] <= s_word;
    end
    // ---- stage p1: RAM read into the source output register ----
    if (fetch) begin
      out_word_p1 <= mem[fetch_ptr[ADDR_W-1:0]];
    end
  end

  // Read side: fetch pointer, retire pointer and output-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      fetch_ptr <= '0;
      vld_p1    <= 1'b0;
    end else begin
      if (fetch) begin
        fetch_ptr <= fetch_ptr + PTR_ONE;
        vld_p1    <= 1'b1;
      end else if (m_hs) begin
        vld_p1 <= 1'b0;
      end
      if (m_hs) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Unpack the output register. Disabled fields drive their fixed defaults.
  always_comb begin
    out_ext      = EXT_W'(out_word_p1);
    m_axis_tdata = out_ext[DATA_WIDTH-1:0];
    m_axis_tkeep = '1;
    m_axis_tlast = 1'b1;
    m_axis_tid   = '0;
    m_axis_tdest = '0;
    m_axis_tuser = '0;
    if (KEEP_ENABLE != 0) m_axis_tkeep = out_ext[KEEP_OFF +: KEEP_WIDTH];
    if (LAST_ENABLE != 0) m_axis_tlast = out_ext[LAST_OFF];
    if (ID_ENABLE   != 0) m_axis_tid   = out_ext[ID_OFF   +: ID_WIDTH];
    if (DEST_ENABLE != 0) m_axis_tdest = out_ext[DEST_OFF +: DEST_WIDTH];
    if (USER_ENABLE != 0) m_axis_tuser = out_ext[USER_OFF +: USER_WIDTH];
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: one non-frame instance (a_*) and one frame-mode instance
// with bad-frame dropping (b_*), both DEPTH=16, 8-bit data.
module tb_axis_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Non-frame instance
  logic [7:0] a_s_tdata;  logic [0:0] a_s_tkeep;  logic a_s_tvalid, a_s_tready, a_s_tlast;
  logic [7:0] a_s_tid, a_s_tdest;  logic [0:0] a_s_tuser;
  logic [7:0] a_m_tdata;  logic [0:0] a_m_tkeep;  logic a_m_tvalid, a_m_tready, a_m_tlast;
  logic [7:0] a_m_tid, a_m_tdest;  logic [0:0] a_m_tuser;
  logic [4:0] a_depth, a_depth_c;  logic a_ovf, a_bad, a_good;

  // Frame instance
  logic [7:0] b_s_tdata;  logic [0:0] b_s_tkeep;  logic b_s_tvalid, b_s_tready, b_s_tlast;
  logic [7:0] b_s_tid, b_s_tdest;  logic [0:0] b_s_tuser;
  logic [7:0] b_m_tdata;  logic [0:0] b_m_tkeep;  logic b_m_tvalid, b_m_tready, b_m_tlast;
  logic [7:0] b_m_tid, b_m_tdest;  logic [0:0] b_m_tuser;
  logic [4:0] b_depth, b_depth_c;  logic b_ovf, b_bad, b_good;

  axis_fifo #(.DEPTH(16), .DATA_WIDTH(8)) u_fifo_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tready(a_s_tready), .s_axis_tlast(a_s_tlast), .s_axis_tid(a_s_tid),
    .s_axis_tdest(a_s_tdest), .s_axis_tuser(a_s_tuser),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tready(a_m_tready), .m_axis_tlast(a_m_tlast), .m_axis_tid(a_m_tid),
    .m_axis_tdest(a_m_tdest), .m_axis_tuser(a_m_tuser),
    .status_depth(a_depth), .status_depth_commit(a_depth_c),
    .status_overflow(a_ovf), .status_bad_frame(a_bad), .status_good_frame(a_good)
  );

  axis_fifo #(.DEPTH(16), .DATA_WIDTH(8), .FRAME_FIFO(1), .DROP_BAD_FRAME(1),
              .USER_ENABLE(1)) u_fifo_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tready(b_s_tready), .s_axis_tlast(b_s_tlast), .s_axis_tid(b_s_tid),
    .s_axis_tdest(b_s_tdest), .s_axis_tuser(b_s_tuser),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast), .m_axis_tid(b_m_tid),
    .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser),
    .status_depth(b_depth), .status_depth_commit(b_depth_c),
    .status_overflow(b_ovf), .status_bad_frame(b_bad), .status_good_frame(b_good)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model for the non-frame FIFO: words accepted but not yet delivered.
  logic [7:0] aq[$];

  // One clock cycle on instance A. Called at a falling edge: drive the inputs,
  // compare against the model, and account for the handshakes of the next
  // rising edge.
  task automatic a_cycle(input logic vld, input logic [7:0] d, input logic rdy,
                         output logic acc);
    int sz;
    sz = aq.size();
    a_s_tvalid = vld;
    a_s_tdata  = d;
    a_m_tready = rdy;
    #1;
    check("a_depth", 32'(a_depth), 32'(sz));
    check("a_s_tready", 32'(a_s_tready), 32'(sz < 16));
    check("a_pulses", {29'd0, a_ovf, a_bad, a_good}, 32'd0);
    if (a_m_tvalid && rdy) begin
      check("a_out_nonempty", 32'(a_m_tvalid), 32'(sz != 0));
      if (sz != 0) begin
        check("a_data", 32'(a_m_tdata), 32'(aq[0]));
        void'(aq.pop_front());
      end
    end
    acc = vld && a_s_tready;
    if (acc) aq.push_back(d);
    @(negedge clk);
  endtask

  task automatic a_drain();
    int cyc;
    logic acc;
    cyc = 0;
    while (aq.size() != 0 && cyc < 200) begin
      a_cycle(1'b0, 8'h00, 1'b1, acc);
      cyc++;
    end
    check("a_drained", 32'(aq.size()), 32'd0);
    a_cycle(1'b0, 8'h00, 1'b0, acc);
    check("a_idle_vld", 32'(a_m_tvalid), 32'd0);
  endtask

  // Random valid/ready traffic. The ready probability alternates in phases,
  // so the FIFO both fills to full and drains to empty many times.
  task automatic a_random(input int nwords);
    int sent, cyc;
    logic acc, vld, rdy;
    logic [7:0] d;
    sent = 0;
    cyc  = 0;
    d    = 8'($urandom);
    while (sent < nwords && cyc < 20 * nwords) begin
      vld = ($urandom_range(0, 3) != 0);
      if (((cyc / 50) % 2) == 0) rdy = ($urandom_range(0, 3) == 0);
      else                       rdy = ($urandom_range(0, 3) != 0);
      a_cycle(vld, d, rdy, acc);
      if (acc) begin
        sent++;
        d = 8'($urandom);
      end
      cyc++;
    end
    check("a_rand_sent", 32'(sent), 32'(nwords));
  endtask

  // Monitor for instance B: delivered words and status pulses.
  logic [7:0] bq_out[$];
  int b_good_n, b_bad_n, b_ovf_n;

  always @(negedge clk) begin
    #1;
    if (b_m_tvalid && b_m_tready) bq_out.push_back(b_m_tdata);
    if (b_good) b_good_n++;
    if (b_bad)  b_bad_n++;
    if (b_ovf)  b_ovf_n++;
  end

  task automatic b_clear();
    bq_out.delete();
    b_good_n = 0;
    b_bad_n  = 0;
    b_ovf_n  = 0;
  endtask

  // Present one word on B's sink until it is accepted. Returns at the falling
  // edge after the accepting rising edge.
  task automatic b_word(input logic [7:0] d, input logic last, input logic user);
    int waited;
    waited     = 0;
    b_s_tvalid = 1'b1;
    b_s_tdata  = d;
    b_s_tlast  = last;
    b_s_tuser  = user;
    #1;
    while (!b_s_tready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 50) check("b_ready_timeout", 32'(b_s_tready), 32'd1);
    @(negedge clk);
    b_s_tvalid = 1'b0;
    b_s_tlast  = 1'b0;
    b_s_tuser  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    rst_n = 1'b0;
    a_s_tdata = '0; a_s_tkeep = '1; a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    a_s_tid = '0; a_s_tdest = '0; a_s_tuser = '0; a_m_tready = 1'b0;
    b_s_tdata = '0; b_s_tkeep = '1; b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    b_s_tid = '0; b_s_tdest = '0; b_s_tuser = '0; b_m_tready = 1'b0;
    b_clear();

    // Reset state
    #12;
    check("rst_a_s_tready", 32'(a_s_tready), 32'd0);
    check("rst_a_m_tvalid", 32'(a_m_tvalid), 32'd0);
    check("rst_a_depth", 32'(a_depth), 32'd0);
    check("rst_a_depth_c", 32'(a_depth_c), 32'd0);
    check("rst_b_s_tready", 32'(b_s_tready), 32'd0);
    check("rst_b_m_tvalid", 32'(b_m_tvalid), 32'd0);
    check("rst_b_pulses", {29'd0, b_ovf, b_bad, b_good}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_a_s_tready_pre", 32'(a_s_tready), 32'd0);
    @(negedge clk);
    check("rel_a_s_tready", 32'(a_s_tready), 32'd1);
    check("rel_b_s_tready", 32'(b_s_tready), 32'd1);

    // Non-frame latency: a word accepted at edge N is valid after edge N+1
    a_cycle(1'b1, 8'hA5, 1'b0, acc);
    check("lat_vld_n", 32'(a_m_tvalid), 32'd0);
    a_cycle(1'b0, 8'h00, 1'b0, acc);
    check("lat_vld_n1", 32'(a_m_tvalid), 32'd1);
    check("lat_data_n1", 32'(a_m_tdata), 32'hA5);
    a_cycle(1'b0, 8'h00, 1'b0, acc);
    check("hold_vld", 32'(a_m_tvalid), 32'd1);
    check("hold_data", 32'(a_m_tdata), 32'hA5);
    a_drain();

    // Fill to full with the source stalled, then one read frees a slot a cycle later
    for (int i = 0; i < 16; i++) a_cycle(1'b1, 8'(8'h10 + i), 1'b0, acc);
    a_cycle(1'b0, 8'h00, 1'b0, acc);
    a_cycle(1'b0, 8'h00, 1'b1, acc);
    a_cycle(1'b1, 8'h77, 1'b0, acc);
    a_drain();

    // Random traffic with wrap-around
    a_random(1000);
    a_drain();

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 5; i++) a_cycle(1'b1, 8'(8'hC0 + i), 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a_m_tvalid", 32'(a_m_tvalid), 32'd0);
    check("mid_rst_a_depth", 32'(a_depth), 32'd0);
    check("mid_rst_a_depth_c", 32'(a_depth_c), 32'd0);
    check("mid_rst_a_s_tready", 32'(a_s_tready), 32'd0);
    aq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_random(200);
    a_drain();

    // Frame mode: 3-word good frame
    b_m_tready = 1'b1;
    b_clear();
    b_word(8'h31, 1'b0, 1'b0);
    check("f3_vld_w1", 32'(b_m_tvalid), 32'd0);
    check("f3_commit_w1", 32'(b_depth_c), 32'd0);
    b_word(8'h32, 1'b0, 1'b0);
    check("f3_vld_w2", 32'(b_m_tvalid), 32'd0);
    check("f3_depth_w2", 32'(b_depth), 32'd2);
    b_word(8'h33, 1'b1, 1'b0);
    check("f3_vld_last", 32'(b_m_tvalid), 32'd0);
    check("f3_commit_last", 32'(b_depth_c), 32'd3);
    check("f3_good_pulse", 32'(b_good), 32'd1);
    repeat (8) @(negedge clk);
    check("f3_nwords", 32'(bq_out.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < bq_out.size()) check("f3_word", 32'(bq_out[i]), 32'(8'h31 + i));
    check("f3_good_n", 32'(b_good_n), 32'd1);
    check("f3_depth_end", 32'(b_depth), 32'd0);

    // Frame mode: bad frame is dropped
    b_clear();
    b_word(8'h41, 1'b0, 1'b0);
    b_word(8'h42, 1'b1, 1'b1);
    check("bad_pulse", 32'(b_bad), 32'd1);
    check("bad_depth", 32'(b_depth), 32'd0);
    repeat (8) @(negedge clk);
    check("bad_nwords", 32'(bq_out.size()), 32'd0);
    check("bad_n", 32'(b_bad_n), 32'd1);
    check("bad_good_n", 32'(b_good_n), 32'd0);
    check("bad_ovf_n", 32'(b_ovf_n), 32'd0);

    // Frame mode: oversize frame is dropped with ready held high
    b_clear();
    for (int i = 0; i < 20; i++) begin
      check("ovs_ready", 32'(b_s_tready), 32'd1);
      b_word(8'(8'h80 + i), (i == 19), 1'b0);
    end
    check("ovs_pulse", 32'(b_ovf), 32'd1);
    repeat (8) @(negedge clk);
    check("ovs_ovf_n", 32'(b_ovf_n), 32'd1);
    check("ovs_nwords", 32'(bq_out.size()), 32'd0);
    check("ovs_good_n", 32'(b_good_n), 32'd0);
    check("ovs_depth", 32'(b_depth), 32'd0);

    // Frame mode: recovery after a drop
    b_clear();
    for (int i = 0; i < 4; i++) b_word(8'(8'h51 + i), (i == 3), 1'b0);
    repeat (8) @(negedge clk);
    check("rec_nwords", 32'(bq_out.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < bq_out.size()) check("rec_word", 32'(bq_out[i]), 32'(8'h51 + i));

    // Frame mode: output holds steady under backpressure
    b_clear();
    b_m_tready = 1'b0;
    b_word(8'h61, 1'b0, 1'b0);
    b_word(8'h62, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("bp_vld", 32'(b_m_tvalid), 32'd1);
    check("bp_data", 32'(b_m_tdata), 32'h61);
    @(negedge clk);
    check("bp_data_hold", 32'(b_m_tdata), 32'h61);
    check("bp_depth_c", 32'(b_depth_c), 32'd2);
    b_m_tready = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_nwords", 32'(bq_out.size()), 32'd2);
    for (int i = 0; i < 2; i++)
      if (i < bq_out.size()) check("bp_word", 32'(bq_out[i]), 32'(8'h61 + i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
